// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and LSU state type.
// Holds funct3 codes and the access-rejection helper.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // One-hot so each memory strobe is a single flop bit.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    READ  = 3'b001,
    WRITE = 3'b010,
    RESP  = 3'b100
  } lsu_state_t;

  // Reserved codes always reject; unsigned stores do not exist.
  function automatic logic lsu_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo,
    input logic       chk
  );
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = chk & lo[0];
      F3_W:    bad = chk & (lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | (chk & lo[0]);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half extraction for loads and merge for sub-word stores.
// Ports: f3, off, word in; ldata (load result), mdata (store word) out.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    unique case (f3)
      F3_B:    ldata = {{24{b[7]}}, b};
      F3_H:    ldata = {{16{h[15]}}, h};
      F3_BU:   ldata = {24'h0, b};
      F3_HU:   ldata = {16'h0, h};
      default: ldata = word;
    endcase
  end

  always_comb begin
    mdata = word;
    unique case (f3)
      F3_B:    mdata[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    mdata[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: mdata = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, RMW for SB/SH.
// Ports: req_* from core, resp_*/rdata back, Mem* to a word memory.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic CHK = (CHECK_ALIGN != 0);

  lsu_state_t  state, nstate;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [31:0] ldata, mdata;
  logic        accept, bad;

  assign accept = req_valid & (state == IDLE);
  assign bad    = lsu_bad(req_we, funct3, addr[1:0], CHK);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)
            nstate = RESP;
          else if (req_we && funct3 == F3_W)
            nstate = WRITE;
          else
            nstate = READ;
        end
      end
      READ:    nstate = we_q ? WRITE : RESP;
      WRITE:   nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      state <= nstate;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= bad;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == READ)
        word_q <= mem_rdata;
    end
  end

  lsu_align u_align (
    .f3    (f3_q),
    .off   (addr_q[1:0]),
    .word  (word_q),
    .wdata (wdata_q),
    .ldata (ldata),
    .mdata (mdata)
  );

  assign req_ready    = (state == IDLE);
  assign MemRead      = state[0];
  assign MemWrite     = state[1];
  assign resp_valid   = state[2];
  assign misalign_err = resp_valid & err_q;
  assign rdata        = (resp_valid && !we_q && !err_q) ? ldata : 32'h0;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wdata    = mdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-level model.
// Two instances: CHECK_ALIGN=1 (main) and CHECK_ALIGN=0 (dut0).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        req_ready, resp_valid, misalign_err, MemRead, MemWrite;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        req_ready0, resp_valid0, misalign_err0, MemRead0, MemWrite0;
  logic [31:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 1)
      return 32'h8899AABB;
    return (32'(i) * 32'h01030507) ^ 32'hA5A50000;
  endfunction

  assign mem_rdata  = mem[mem_addr[5:2]];
  assign mem_rdata0 = mem[mem_addr0[5:2]];

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= init_word(i);
    end else if (MemWrite) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  load_store_unit #(.CHECK_ALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata),
    .misalign_err(misalign_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  load_store_unit #(.CHECK_ALIGN(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid0), .rdata(rdata0),
    .misalign_err(misalign_err0),
    .MemRead(MemRead0), .MemWrite(MemWrite0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request to dut and compare against the model.
  task automatic run(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] o_rd, output logic [31:0] o_wd);
    logic [31:0] w, ev, ew, v;
    logic        ee;
    int          el, erd, ewr, sh, hs;
    int          lat, nrd, nwr, both;
    logic [31:0] gr;
    logic        ge;
    w  = ref_mem[a[5:2]];
    sh = int'(a[1:0]) * 8;
    hs = a[1] ? 16 : 0;
    ee = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
         ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ||
         (f3 == 3'd2 && a[1:0] != 2'b00);
    ev = 0; ew = 0; erd = 0; ewr = 0; el = 1;
    if (!ee) begin
      if (!we) begin
        el = 2; erd = 1;
        case (f3)
          3'd0, 3'd4: begin
            v = (w >> sh) & 32'hFF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
          end
          3'd1, 3'd5: begin
            v = (w >> hs) & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
          end
          default: v = w;
        endcase
        ev = v;
      end else begin
        ewr = 1;
        if (f3 == 3'd2) begin
          el = 2; ew = wd;
        end else begin
          el = 3; erd = 1;
          if (f3 == 3'd0)
            ew = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          else
            ew = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
        end
        ref_mem[a[5:2]] = ew;
      end
    end
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'd1);
    chk("resp_once", 32'(resp_valid), 32'd0);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; both = 0; gr = 0; ge = 0; o_wd = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; o_wd = mem_wdata; end
      if (MemRead && MemWrite) both++;
      if (resp_valid) begin lat = k; gr = rdata; ge = misalign_err; end
    end
    chk("latency", lat, el);
    chk("rdata", gr, ev);
    chk("misalign", 32'(ge), 32'(ee));
    chk("nread", nrd, erd);
    chk("nwrite", nwr, ewr);
    chk("both_hi", both, 0);
    if (ewr != 0) chk("mem_wdata", o_wd, ew);
    o_rd = gr;
  endtask

  initial begin
    logic [31:0] rd, wv;
    logic [2:0]  f3;
    logic [31:0] a;
    int          bad_rv;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rd", 32'(MemRead), 32'd0);
    chk("rst_wr", 32'(MemWrite), 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    init = 1'b0;
    rst_n = 1'b1;

    run(1'b0, 3'b000, 32'h4, 32'h0, rd, wv);
    chk("lb_4", rd, 32'hFFFFFFBB);
    run(1'b0, 3'b100, 32'h7, 32'h0, rd, wv);
    chk("lbu_7", rd, 32'h00000088);
    run(1'b0, 3'b001, 32'h6, 32'h0, rd, wv);
    chk("lh_6", rd, 32'hFFFF8899);

    // dut0 ignores alignment: LW at 0x6 returns mem[1].
    @(negedge clk);
    req_valid0 = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h6;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    chk("na_read", 32'(MemRead0), 32'd1);
    @(negedge clk);
    chk("na_resp", 32'(resp_valid0), 32'd1);
    chk("na_rdata", rdata0, 32'h8899AABB);
    chk("na_err", 32'(misalign_err0), 32'd0);
    chk("na_wr", 32'(MemWrite0), 32'd0);

    run(1'b0, 3'b010, 32'h6, 32'h0, rd, wv);
    run(1'b1, 3'b000, 32'h5, 32'h12, rd, wv);
    chk("sb_wdata", wv, 32'h889912BB);
    run(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rd, wv);
    run(1'b0, 3'b010, 32'h8, 32'h0, rd, wv);
    chk("lw_8", rd, 32'hDEADBEEF);
    run(1'b0, 3'b111, 32'h0, 32'h0, rd, wv);
    run(1'b1, 3'b011, 32'hC, 32'h5, rd, wv);

    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run(1'($urandom_range(0, 1)), f3, a, $urandom, rd, wv);
    end

    // Reset in WRITE aborts the store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
    addr = 32'h10; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_inwr", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr", 32'(MemWrite), 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bad_rv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) bad_rv++;
    end
    chk("abort_noresp", bad_rv, 0);
    chk("abort_ready2", 32'(req_ready), 32'd1);
    run(1'b0, 3'b010, 32'h10, 32'h0, rd, wv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
